hilo_mult_ctrl: RTL and testbench

//  Multicycle controller and HI/LO result register for the 32-bit combinational multiplier.
//  - Registers the operands and drives them to the external multiplier array.
//  - Selects signed or unsigned mode.
//  - Waits LATENCY cycles so the array is constrained as a multicycle path.
//  - Captures the 64-bit product into HI/LO.

---
 rtl/hilo_mult_ctrl_if.sv | 35 +++
 rtl/hilo_mult_ctrl.sv | 87 ++++++++
 tb/tb_hilo_mult_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mult_ctrl_if.sv
// rtl/hilo_mult_ctrl_if.sv - execute-stage, multiplier-array and HI/LO signals of the multiply controller
interface hilo_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             start_ack;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             mul_signed;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             mt_ack;
  logic             rd_req;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  start, is_signed, op_a, op_b, prod_hi, prod_lo, mthi, mtlo, wdata, rd_req,
    output start_ack, mcand, mplier, mul_signed, mt_ack, stall, busy, done, hi, lo
  );

  modport master (
    output start, is_signed, op_a, op_b, prod_hi, prod_lo, mthi, mtlo, wdata, rd_req,
    input  start_ack, mcand, mplier, mul_signed, mt_ack, stall, busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_mult_ctrl.sv
// rtl/hilo_mult_ctrl.sv - multicycle multiply controller with HI/LO result registers
// Operands are held stable while the external array settles for LATENCY cycles.
module hilo_mult_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input logic           clk,
  input logic           rst,
  hilo_mult_ctrl_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             signed_q;
  logic             done_q;
  logic             busy;
  logic             start_ack;
  logic             mt_ack;
  logic             capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      mcand_q  <= '0;
      mplier_q <= '0;
      signed_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= capture;
      if (start_ack) begin
        mcand_q  <= bus.op_a;
        mplier_q <= bus.op_b;
        signed_q <= bus.is_signed;
        cnt      <= CNT_INIT;
      end else if (busy && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // capture and MTHI/MTLO are exclusive: mt_ack is never raised while busy
      if (capture) begin
        hi_q <= bus.prod_hi;
        lo_q <= bus.prod_lo;
      end else if (mt_ack) begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = BUSY;
      BUSY:    if (cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == BUSY);
    capture   = busy && (cnt == 4'd0);
    start_ack = bus.start & ~busy;
    mt_ack    = (bus.mthi | bus.mtlo) & ~busy & ~bus.start;
  end

  assign bus.start_ack  = start_ack;
  assign bus.mt_ack     = mt_ack;
  assign bus.busy       = busy;
  assign bus.stall      = bus.rd_req & busy;
  assign bus.done       = done_q;
  assign bus.mcand      = mcand_q;
  assign bus.mplier     = mplier_q;
  assign bus.mul_signed = signed_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// tb/tb_hilo_mult_ctrl.sv - directed bench for hilo_mult_ctrl at LATENCY 4 and LATENCY 1
module tb_hilo_mult_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  hilo_mult_ctrl_if #(.WIDTH(32)) if4 ();
  hilo_mult_ctrl_if #(.WIDTH(32)) if1 ();

  hilo_mult_ctrl #(.WIDTH(32), .LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  hilo_mult_ctrl #(.WIDTH(32), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  function automatic logic [63:0] mul_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  assign {if4.prod_hi, if4.prod_lo} = mul_model(if4.mul_signed, if4.mcand, if4.mplier);
  assign {if1.prod_hi, if1.prod_lo} = mul_model(if1.mul_signed, if1.mcand, if1.mplier);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    total++; if (if4.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", if4.hi); end
    total++; if (if4.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", if4.lo); end
    total++; if (if4.mcand !== 32'h0 || if4.mplier !== 32'h0) begin bad++; $display("FAIL reset_ops got=%h/%h exp=0/0", if4.mcand, if4.mplier); end
    total++; if ({if4.busy, if4.done, if4.mul_signed} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {if4.busy, if4.done, if4.mul_signed}); end
    total++; if ({if1.busy, if1.done} !== 2'b00) begin bad++; $display("FAIL reset_flags_l1 got=%b exp=00", {if1.busy, if1.done}); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    int dones;
    if4.start = 1'b1; if4.is_signed = 1'b1; if4.op_a = 32'hFFFFFFFD; if4.op_b = 32'h5;
    step();
    if4.start = 1'b0;
    total++; if (if4.busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b exp=1", if4.busy); end
    step();
    step();
    rst = 1'b1;
    #1;
    total++; if (if4.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_clr got=%b exp=0", if4.busy); end
    total++; if (if4.mcand !== 32'h0) begin bad++; $display("FAIL rstmid_mcand got=%h exp=0", if4.mcand); end
    step();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if4.done === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL rstmid_done got=%0d exp=0", dones); end
    total++; if (if4.hi !== 32'h0 || if4.lo !== 32'h0) begin bad++; $display("FAIL rstmid_hilo got=%h/%h exp=0/0", if4.hi, if4.lo); end
  endtask

  task automatic test_mthi_mtlo;
    if4.mthi = 1'b1; if4.wdata = 32'h12345678;
    #1;
    total++; if (if4.mt_ack !== 1'b1) begin bad++; $display("FAIL mthi_ack got=%b exp=1", if4.mt_ack); end
    step();
    if4.mthi = 1'b0;
    total++; if (if4.hi !== 32'h12345678 || if4.lo !== 32'h0) begin bad++; $display("FAIL mthi_write got=%h/%h exp=12345678/0", if4.hi, if4.lo); end
    if4.mtlo = 1'b1; if4.wdata = 32'hCAFEF00D;
    step();
    if4.mtlo = 1'b0;
    total++; if (if4.hi !== 32'h12345678 || if4.lo !== 32'hCAFEF00D) begin bad++; $display("FAIL mtlo_write got=%h/%h exp=12345678/cafef00d", if4.hi, if4.lo); end
    if4.mthi = 1'b1; if4.mtlo = 1'b1; if4.wdata = 32'hA5A5A5A5;
    step();
    if4.mthi = 1'b0; if4.mtlo = 1'b0;
    total++; if (if4.hi !== 32'hA5A5A5A5 || if4.lo !== 32'hA5A5A5A5) begin bad++; $display("FAIL mtboth_write got=%h/%h exp=a5a5a5a5/a5a5a5a5", if4.hi, if4.lo); end
  endtask

  task automatic test_signed;
    if4.start = 1'b1; if4.is_signed = 1'b1; if4.op_a = 32'hFFFFFFFD; if4.op_b = 32'h5;
    #1;
    total++; if (if4.start_ack !== 1'b1) begin bad++; $display("FAIL signed_ack got=%b exp=1", if4.start_ack); end
    step();
    if4.start = 1'b0;
    total++; if (if4.mcand !== 32'hFFFFFFFD || if4.mplier !== 32'h5 || if4.mul_signed !== 1'b1) begin bad++; $display("FAIL signed_latch got=%h/%h/%b exp=fffffffd/5/1", if4.mcand, if4.mplier, if4.mul_signed); end
    for (int i = 1; i < 4; i++) begin
      step();
      total++; if (if4.done !== 1'b0 || if4.busy !== 1'b1 || if4.hi !== 32'hA5A5A5A5) begin bad++; $display("FAIL signed_wait%0d got=done%b busy%b hi%h exp=done0 busy1 hia5a5a5a5", i, if4.done, if4.busy, if4.hi); end
    end
    step();
    total++; if (if4.done !== 1'b1 || if4.busy !== 1'b0) begin bad++; $display("FAIL signed_done got=done%b busy%b exp=done1 busy0", if4.done, if4.busy); end
    total++; if (if4.hi !== 32'hFFFFFFFF || if4.lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL signed_prod got=%h/%h exp=ffffffff/fffffff1", if4.hi, if4.lo); end
    step();
    total++; if (if4.done !== 1'b0) begin bad++; $display("FAIL signed_done_pulse got=%b exp=0", if4.done); end
  endtask

  task automatic test_unsigned;
    if4.start = 1'b1; if4.is_signed = 1'b0; if4.op_a = 32'hFFFFFFFF; if4.op_b = 32'hFFFFFFFF;
    step();
    if4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (if4.mul_signed !== 1'b0 || if4.busy !== 1'b1) begin bad++; $display("FAIL unsigned_mode%0d got=sgn%b busy%b exp=sgn0 busy1", i, if4.mul_signed, if4.busy); end
      step();
    end
    total++; if (if4.done !== 1'b1) begin bad++; $display("FAIL unsigned_done got=%b exp=1", if4.done); end
    total++; if (if4.hi !== 32'hFFFFFFFE || if4.lo !== 32'h00000001) begin bad++; $display("FAIL unsigned_prod got=%h/%h exp=fffffffe/00000001", if4.hi, if4.lo); end
  endtask

  task automatic test_interlock;
    if4.rd_req = 1'b1;
    if4.start = 1'b1; if4.is_signed = 1'b0; if4.op_a = 32'h00010000; if4.op_b = 32'h00010000;
    #1;
    total++; if (if4.stall !== 1'b0) begin bad++; $display("FAIL lock_stall0 got=%b exp=0", if4.stall); end
    step();
    if4.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total++; if (if4.stall !== 1'b1) begin bad++; $display("FAIL lock_stall%0d got=%b exp=1", i, if4.stall); end
      step();
    end
    total++; if (if4.stall !== 1'b0 || if4.done !== 1'b1) begin bad++; $display("FAIL lock_release got=stall%b done%b exp=stall0 done1", if4.stall, if4.done); end
    total++; if (if4.hi !== 32'h1 || if4.lo !== 32'h0) begin bad++; $display("FAIL lock_prod got=%h/%h exp=1/0", if4.hi, if4.lo); end
    if4.rd_req = 1'b0;
  endtask

  task automatic test_collisions;
    if4.mthi = 1'b1; if4.wdata = 32'hBAD0BAD0;
    if4.start = 1'b1; if4.is_signed = 1'b1; if4.op_a = 32'h2; if4.op_b = 32'h3;
    #1;
    total++; if (if4.mt_ack !== 1'b0 || if4.start_ack !== 1'b1) begin bad++; $display("FAIL coll_prio got=mt%b st%b exp=mt0 st1", if4.mt_ack, if4.start_ack); end
    step();
    total++; if (if4.hi !== 32'h1 || if4.mcand !== 32'h2) begin bad++; $display("FAIL coll_hi_keep got=%h/%h exp=1/2", if4.hi, if4.mcand); end
    if4.op_a = 32'h0000DEAD;
    #1;
    total++; if (if4.start_ack !== 1'b0 || if4.mt_ack !== 1'b0) begin bad++; $display("FAIL coll_busy_ack got=st%b mt%b exp=st0 mt0", if4.start_ack, if4.mt_ack); end
    step();
    total++; if (if4.mcand !== 32'h2) begin bad++; $display("FAIL coll_mcand got=%h exp=2", if4.mcand); end
    step();
    step();
    total++; if (if4.start_ack !== 1'b0 || if4.busy !== 1'b1) begin bad++; $display("FAIL coll_capture_cycle got=st%b busy%b exp=st0 busy1", if4.start_ack, if4.busy); end
    step();
    total++; if (if4.done !== 1'b1 || if4.hi !== 32'h0 || if4.lo !== 32'h6 || if4.mcand !== 32'h2) begin bad++; $display("FAIL coll_result got=done%b %h/%h mc%h exp=done1 0/6 mc2", if4.done, if4.hi, if4.lo, if4.mcand); end
    total++; if (if4.start_ack !== 1'b1 || if4.mt_ack !== 1'b0) begin bad++; $display("FAIL coll_done_ack got=st%b mt%b exp=st1 mt0", if4.start_ack, if4.mt_ack); end
    if4.start = 1'b0; if4.mthi = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    int dones;
    dones = 0;
    if1.start = 1'b1; if1.is_signed = 1'b0; if1.op_a = 32'h7; if1.op_b = 32'h6;
    #1;
    total++; if (if1.start_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b exp=1", if1.start_ack); end
    step();
    if1.start = 1'b0;
    if (if1.done === 1'b1) dones++;
    total++; if (if1.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy1 got=%b exp=1", if1.busy); end
    step();
    if (if1.done === 1'b1) dones++;
    total++; if (if1.done !== 1'b1 || if1.hi !== 32'h0 || if1.lo !== 32'h2A) begin bad++; $display("FAIL b2b_prod1 got=done%b %h/%h exp=done1 0/2a", if1.done, if1.hi, if1.lo); end
    if1.start = 1'b1; if1.op_a = 32'h00010000; if1.op_b = 32'h00010000;
    #1;
    total++; if (if1.start_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%b exp=1", if1.start_ack); end
    step();
    if1.start = 1'b0;
    if (if1.done === 1'b1) dones++;
    step();
    if (if1.done === 1'b1) dones++;
    total++; if (if1.hi !== 32'h1 || if1.lo !== 32'h0) begin bad++; $display("FAIL b2b_prod2 got=%h/%h exp=1/0", if1.hi, if1.lo); end
    step();
    if (if1.done === 1'b1) dones++;
    step();
    if (if1.done === 1'b1) dones++;
    total++; if (dones !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if4.start = 1'b0; if4.is_signed = 1'b0; if4.op_a = '0; if4.op_b = '0;
    if4.mthi = 1'b0; if4.mtlo = 1'b0; if4.wdata = '0; if4.rd_req = 1'b0;
    if1.start = 1'b0; if1.is_signed = 1'b0; if1.op_a = '0; if1.op_b = '0;
    if1.mthi = 1'b0; if1.mtlo = 1'b0; if1.wdata = '0; if1.rd_req = 1'b0;
    test_reset();
    test_reset_mid_busy();
    test_mthi_mtlo();
    test_signed();
    test_unsigned();
    test_interlock();
    test_collisions();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
